mem_resp_32: RTL and testbench

Word-addressed memory responder that serves the CPU's MAR/MDR memory port. It accepts a read or write request, inserts a programmable number of wait states, then commits the write or returns read data on `Mdatain`. `Mdatain` feeds the MDR input mux. A one-cycle `done` pulse tells the control unit that the MDR may latch, or that the write has landed.

---
 rtl/mem_resp_32_if.sv | 22 ++
 rtl/mem_resp_32.sv | 118 +++++++++++
 tb/tb_mem_resp_32.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_32_if.sv
// Memory request/response bundle between CPU MAR/MDR port and mem_resp_32.
// Master is the CPU side, slave is the responder.
interface mem_resp_32_if;
    logic        read;
    logic        write;
    logic [31:0] MARout;
    logic [31:0] MDRout;
    logic [31:0] Mdatain;
    logic        done;
    logic        busy;
    logic        addr_err;

    modport master (
        output read, write, MARout, MDRout,
        input  Mdatain, done, busy, addr_err
    );

    modport slave (
        input  read, write, MARout, MDRout,
        output Mdatain, done, busy, addr_err
    );
endinterface

// File: rtl/mem_resp_32.sv
// Word-addressed memory responder with programmable wait states.
// Commits writes / returns read data on the edge entering RESP.
module mem_resp_32 #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int WAIT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_resp_32_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nx;
    logic        w_enter;

    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_wr;
    logic        r_err;
    logic [31:0] r_mdata;

    logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

    logic              w_req;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_data;
    logic              w_sel_wr;
    logic              w_in_rng;
    logic [ADDR_W-1:0] w_idx;

    // With WAIT=0 the entry edge is the capture edge, so use live inputs.
    assign w_req      = bus.read | bus.write;
    assign w_sel_addr = (r_state == S_IDLE) ? bus.MARout : r_addr;
    assign w_sel_data = (r_state == S_IDLE) ? bus.MDRout : r_data;
    assign w_sel_wr   = (r_state == S_IDLE) ? bus.write  : r_wr;
    assign w_in_rng   = w_sel_addr < 32'(DEPTH);
    assign w_idx      = w_sel_addr[ADDR_W-1:0];

    always_comb begin
        w_next   = r_state;
        w_cnt_nx = r_cnt;
        w_enter  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_cnt_nx = 4'(WAIT);
                    if (WAIT == 0) begin
                        w_next  = S_RESP;
                        w_enter = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nx = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next  = S_RESP;
                    w_enter = 1'b1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            r_data  <= 32'h0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_mdata <= 32'h0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nx;
            if (r_state == S_IDLE && w_req) begin
                r_addr <= bus.MARout;
                r_data <= bus.MDRout;
                r_wr   <= bus.write;
            end
            if (w_enter) begin
                r_err <= !w_in_rng;
                if (!w_sel_wr) begin
                    r_mdata <= w_in_rng ? r_mem[w_idx] : 32'h0;
                end
            end
        end
    end

    // Gated by reset so a request held during reset never lands.
    always_ff @(posedge clk) begin
        if (reset && w_enter && w_sel_wr && w_in_rng) begin
            r_mem[w_idx] <= w_sel_data;
        end
    end

    assign bus.Mdatain  = r_mdata;
    assign bus.done     = (r_state == S_RESP);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.addr_err = (r_state == S_RESP) & r_err;

endmodule

// File: tb/tb_mem_resp_32.sv
// Directed bench for mem_resp_32: WAIT=2 and WAIT=0 instances.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_resp_32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mem_resp_32_if b2 ();
    mem_resp_32_if b0 ();

    mem_resp_32 #(.DEPTH(512), .ADDR_W(9), .WAIT(2)) u2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    mem_resp_32 #(.DEPTH(512), .ADDR_W(9), .WAIT(0)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Present a request for one capture edge on the WAIT=2 unit.
    // Returns at the falling edge right after the capture edge.
    task automatic issue2(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        b2.read   = rd;
        b2.write  = wr;
        b2.MARout = a;
        b2.MDRout = d;
        @(negedge clk);
        b2.read  = 1'b0;
        b2.write = 1'b0;
    endtask

    task automatic test_reset();
        b2.read = 0; b2.write = 0; b2.MARout = 0; b2.MDRout = 0;
        b0.read = 0; b0.write = 0; b0.MARout = 0; b0.MDRout = 0;
        #1 reset = 1'b0;
        #2;
        n_vec++;
        if (b2.Mdatain !== 32'h0 || b2.done !== 1'b0 ||
            b2.busy !== 1'b0 || b2.addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outs: got md=%h d=%b b=%b e=%b want all 0",
                     b2.Mdatain, b2.done, b2.busy, b2.addr_err);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (b2.busy !== 1'b0 || b2.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got busy=%b done=%b want 0 0",
                     b2.busy, b2.done);
        end
        // Async assertion while busy must clear busy before any edge.
        issue2(1'b1, 1'b0, 32'd0, 32'd0);
        n_vec++;
        if (b2.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy_pre: got %b want 1", b2.busy);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (b2.busy !== 1'b0 || b2.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: got busy=%b done=%b want 0 0",
                     b2.busy, b2.done);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        logic [3:0] ed = 4'b0100;
        logic [3:0] eb = 4'b0111;
        issue2(1'b0, 1'b1, 32'd5, 32'hCAFE_0001);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (b2.done !== ed[i] || b2.busy !== eb[i]) begin
                n_bad++;
                $display("FAIL wr_timing[%0d]: got done=%b busy=%b want %b %b",
                         i, b2.done, b2.busy, ed[i], eb[i]);
            end
            if (i == 2) begin
                n_vec++;
                if (b2.Mdatain !== 32'h0 || b2.addr_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wr_nodata: got md=%h err=%b want 0 0",
                             b2.Mdatain, b2.addr_err);
                end
            end
            if (i < 3) @(negedge clk);
        end
        issue2(1'b1, 1'b0, 32'd5, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (b2.done !== 1'b1 || b2.Mdatain !== 32'hCAFE_0001) begin
            n_bad++;
            $display("FAIL rd5: got done=%b md=%h want 1 cafe0001",
                     b2.done, b2.Mdatain);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (b2.done !== 1'b0 || b2.Mdatain !== 32'hCAFE_0001) begin
                n_bad++;
                $display("FAIL rd5_hold[%0d]: got done=%b md=%h want 0 cafe0001",
                         i, b2.done, b2.Mdatain);
            end
        end
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        b0.read = 1'b1; b0.MARout = 32'd0;
        @(negedge clk);
        b0.read = 1'b0;
        n_vec++;
        if (b0.done !== 1'b1 || b0.busy !== 1'b1 || b0.Mdatain !== 32'h0) begin
            n_bad++;
            $display("FAIL w0_rd0: got done=%b busy=%b md=%h want 1 1 0",
                     b0.done, b0.busy, b0.Mdatain);
        end
        @(negedge clk);
        n_vec++;
        if (b0.done !== 1'b0 || b0.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL w0_idle: got done=%b busy=%b want 0 0",
                     b0.done, b0.busy);
        end
        b0.write = 1'b1; b0.MARout = 32'd3; b0.MDRout = 32'h0000_A5A5;
        @(negedge clk);
        b0.write = 1'b0;
        n_vec++;
        if (b0.done !== 1'b1 || b0.Mdatain !== 32'h0) begin
            n_bad++;
            $display("FAIL w0_wr3: got done=%b md=%h want 1 0",
                     b0.done, b0.Mdatain);
        end
        @(negedge clk);
        b0.read = 1'b1; b0.MARout = 32'd3;
        @(negedge clk);
        b0.read = 1'b0;
        n_vec++;
        if (b0.done !== 1'b1 || b0.Mdatain !== 32'h0000_A5A5) begin
            n_bad++;
            $display("FAIL w0_rd3: got done=%b md=%h want 1 0000a5a5",
                     b0.done, b0.Mdatain);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        issue2(1'b0, 1'b1, 32'd600, 32'h0000_1234);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (b2.done !== 1'b1 || b2.addr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_wr: got done=%b err=%b want 1 1",
                     b2.done, b2.addr_err);
        end
        @(negedge clk);
        n_vec++;
        if (b2.addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_err_drop: got %b want 0", b2.addr_err);
        end
        issue2(1'b1, 1'b0, 32'd600, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (b2.Mdatain !== 32'h0 || b2.addr_err !== 1'b1 || b2.done !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_rd: got md=%h err=%b done=%b want 0 1 1",
                     b2.Mdatain, b2.addr_err, b2.done);
        end
        @(negedge clk);
        issue2(1'b1, 1'b0, 32'd88, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (b2.Mdatain !== 32'h0 || b2.addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL alias88: got md=%h err=%b want 0 0",
                     b2.Mdatain, b2.addr_err);
        end
        @(negedge clk);
        // Both requests high: the write must win.
        issue2(1'b1, 1'b1, 32'd9, 32'h5555_AAAA);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (b2.done !== 1'b1 || b2.Mdatain !== 32'h0) begin
            n_bad++;
            $display("FAIL both_resp: got done=%b md=%h want 1 0",
                     b2.done, b2.Mdatain);
        end
        @(negedge clk);
        issue2(1'b1, 1'b0, 32'd9, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (b2.Mdatain !== 32'h5555_AAAA) begin
            n_bad++;
            $display("FAIL both_rd9: got %h want 5555aaaa", b2.Mdatain);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue2(1'b0, 1'b1, 32'd7, 32'h0000_0777);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        issue2(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFF);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b2.done === 1'b1) seen++;
            @(negedge clk);
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL mid_nodone: got %0d done cycles want 0", seen);
        end
        issue2(1'b1, 1'b0, 32'd7, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (b2.done !== 1'b1 || b2.Mdatain !== 32'h0000_0777) begin
            n_bad++;
            $display("FAIL mid_rd7: got done=%b md=%h want 1 00000777",
                     b2.done, b2.Mdatain);
        end
        @(negedge clk);
    endtask

    task automatic test_held();
        @(negedge clk);
        b2.read = 1'b1; b2.MARout = 32'd5;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 1) b2.MARout = 32'd600;
            if (j == 3) b2.MARout = 32'd5;
            n_vec++;
            if (b2.done !== ((j % 4) == 3)) begin
                n_bad++;
                $display("FAIL held_done[%0d]: got %b want %b",
                         j, b2.done, ((j % 4) == 3));
            end
            if (j == 3) begin
                n_vec++;
                if (b2.Mdatain !== 32'hCAFE_0001 || b2.addr_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL held_addr: got md=%h err=%b want cafe0001 0",
                             b2.Mdatain, b2.addr_err);
                end
            end
        end
        b2.read = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_out_of_range();
        test_reset_mid();
        test_held();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
